egress_arbiter: RTL and testbench

EGRESS_ARBITER -- requirements
Module: egress_arbiter

---
 rtl/egress_pkg.sv | 32 +++
 rtl/rr_pick_4.sv | 36 +++
 rtl/egress_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_egress_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/egress_pkg.sv
// ---------------------------------------------------------------------------
// egress_pkg
// Shared constants for the egress arbiter: datapath width, channel count,
// link-state encodings, FSM state type/encodings and the forwarding-enable
// helper.
// ---------------------------------------------------------------------------
package egress_pkg;

    localparam int DATA_W = 12;
    localparam int NUM_CH = 4;

    // One-hot link-state encodings presented on the state input
    localparam logic [3:0] LINK_RESET  = 4'b0001;
    localparam logic [3:0] LINK_INIT   = 4'b0010;
    localparam logic [3:0] LINK_IDLE   = 4'b0100;
    localparam logic [3:0] LINK_ACTIVE = 4'b1000;

    // Arbiter FSM state
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE    = 2'd0;
    localparam arb_state_t ST_POP     = 2'd1;
    localparam arb_state_t ST_CAPTURE = 2'd2;

    // Last grant after reset is channel 3, so channel 0 is searched first
    localparam logic [1:0] LAST_GRANT_RST = 2'd3;

    // Forwarding is allowed only in the link idle and active states
    function automatic logic fwd_enabled(input logic [3:0] link);
        return (link == LINK_IDLE) || (link == LINK_ACTIVE);
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// ---------------------------------------------------------------------------
// rr_pick_4
// Round-robin pick among four requesters. Search order starts one past the
// last grant and wraps: last+1, last+2, last+3, then last itself.
//
// Ports
//   i_req   [3:0] request vector, bit k = channel k has data
//   i_last  [1:0] previously granted channel
//   o_grant [1:0] selected channel (holds i_last when nothing requests)
//   o_valid       at least one request present
// ---------------------------------------------------------------------------
module rr_pick_4
    import egress_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic [1:0] i_last,
    output logic [1:0] o_grant,
    output logic       o_valid
);

    // NOTE: every output gets a default before the search so that no path
    // leaves it unassigned; otherwise the tool infers a latch.
    always_comb begin
        o_grant = i_last;
        o_valid = 1'b0;
        // Walk from the farthest offset to the nearest so the nearest
        // requesting channel is the one left in o_grant.
        for (int i = NUM_CH; i >= 1; i--) begin
            if (i_req[i_last + 2'(i)]) begin
                o_grant = i_last + 2'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/egress_arbiter.sv
// ---------------------------------------------------------------------------
// egress_arbiter
// Moves 12-bit words from four class FIFOs into one output FIFO with
// round-robin fairness. Each word takes a POP cycle (read strobe) and a
// CAPTURE cycle (read data valid, registered into data_out); push follows in
// the next cycle, so peak throughput is one word every two cycles.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset
//   state [3:0]         link state; 0100/1000 enable forwarding, 0001 clears
//   empty_0..3          class FIFO empty flags
//   data_in_0..3 [11:0] class FIFO read data, valid the cycle after pop
//   pop_0..3            class FIFO read strobes
//   almost_full_out     output FIFO almost-full; blocks new grants only
//   push                output FIFO write strobe
//   data_out [11:0]     output FIFO write data
//   idle                FSM in IDLE with no word in flight
//   word_cnt_0..3 [7:0] per-channel pushed-word counters
//
// Build option
//   ARB_STATS_EN  when defined, word_cnt_0..3 count pushed words per channel
//                 (saturating at 255); otherwise they are tied to zero.
// ---------------------------------------------------------------------------
module egress_arbiter
    import egress_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        state,
    input  logic              empty_0,
    input  logic              empty_1,
    input  logic              empty_2,
    input  logic              empty_3,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic [DATA_W-1:0] data_in_2,
    input  logic [DATA_W-1:0] data_in_3,
    output logic              pop_0,
    output logic              pop_1,
    output logic              pop_2,
    output logic              pop_3,
    input  logic              almost_full_out,
    output logic              push,
    output logic [DATA_W-1:0] data_out,
    output logic              idle,
    output logic [7:0]        word_cnt_0,
    output logic [7:0]        word_cnt_1,
    output logic [7:0]        word_cnt_2,
    output logic [7:0]        word_cnt_3
);

    arb_state_t        r_fsm;
    arb_state_t        w_fsm_next;
    logic [1:0]        r_last_grant;
    logic              r_push;
    logic [DATA_W-1:0] r_data_out;

    logic [3:0]        w_req;
    logic [1:0]        w_pick;
    logic              w_pick_valid;
    logic              w_can_grant;
    logic              w_take;
    logic              w_clear;
    logic [DATA_W-1:0] w_data_sel;

    assign w_req   = {~empty_3, ~empty_2, ~empty_1, ~empty_0};
    assign w_clear = (state == LINK_RESET);

    // New grants need an enabled link, room downstream and a waiting word.
    // Words already in POP/CAPTURE always complete regardless of these.
    assign w_can_grant = fwd_enabled(state) && !almost_full_out && w_pick_valid;

    rr_pick_4 u_rr_pick_4 (
        .i_req   (w_req),
        .i_last  (r_last_grant),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    // Read data of the channel granted for the word currently in CAPTURE
    always_comb begin
        case (r_last_grant)
            2'd0:    w_data_sel = data_in_0;
            2'd1:    w_data_sel = data_in_1;
            2'd2:    w_data_sel = data_in_2;
            default: w_data_sel = data_in_3;
        endcase
    end

    always_comb begin
        w_fsm_next = r_fsm;
        w_take     = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                if (w_can_grant) begin
                    w_fsm_next = ST_POP;
                    w_take     = 1'b1;
                end
            end
            ST_POP: begin
                w_fsm_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Chain straight into the next POP to sustain one word per
                // two cycles
                if (w_can_grant) begin
                    w_fsm_next = ST_POP;
                    w_take     = 1'b1;
                end else begin
                    w_fsm_next = ST_IDLE;
                end
            end
            default: begin
                w_fsm_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm        <= ST_IDLE;
            r_last_grant <= LAST_GRANT_RST;
            r_push       <= 1'b0;
            r_data_out   <= '0;
        end else if (w_clear) begin
            // Link reset state behaves exactly like reset, dropping any
            // word in flight
            r_fsm        <= ST_IDLE;
            r_last_grant <= LAST_GRANT_RST;
            r_push       <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_fsm  <= w_fsm_next;
            r_push <= (r_fsm == ST_CAPTURE);
            if (w_take) begin
                r_last_grant <= w_pick;
            end
            if (r_fsm == ST_CAPTURE) begin
                r_data_out <= w_data_sel;
            end
        end
    end

    // The strobe follows the grant register, which only changes on a grant,
    // so the popped channel is the one found non-empty at grant time
    assign pop_0 = (r_fsm == ST_POP) && (r_last_grant == 2'd0);
    assign pop_1 = (r_fsm == ST_POP) && (r_last_grant == 2'd1);
    assign pop_2 = (r_fsm == ST_POP) && (r_last_grant == 2'd2);
    assign pop_3 = (r_fsm == ST_POP) && (r_last_grant == 2'd3);

    assign push     = r_push;
    assign data_out = r_data_out;
    // The push cycle still counts as in flight
    assign idle     = (r_fsm == ST_IDLE) && !r_push;

`ifdef ARB_STATS_EN
    logic [1:0] r_out_ch;
    logic [7:0] r_word_cnt [NUM_CH];

    // Channel of the word being captured, so the counter bumps on its push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_ch <= '0;
        end else if (r_fsm == ST_CAPTURE) begin
            r_out_ch <= r_last_grant;
        end
    end

    // NOTE: this small register array is reset because its contents are
    // architecturally visible; wide data storage normally is left unreset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_word_cnt[i] <= '0;
            end
        end else if (w_clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_word_cnt[i] <= '0;
            end
        end else if (r_push && (r_word_cnt[r_out_ch] != 8'hFF)) begin
            r_word_cnt[r_out_ch] <= r_word_cnt[r_out_ch] + 8'd1;
        end
    end

    assign word_cnt_0 = r_word_cnt[0];
    assign word_cnt_1 = r_word_cnt[1];
    assign word_cnt_2 = r_word_cnt[2];
    assign word_cnt_3 = r_word_cnt[3];
`else
    assign word_cnt_0 = '0;
    assign word_cnt_1 = '0;
    assign word_cnt_2 = '0;
    assign word_cnt_3 = '0;
`endif

endmodule

// File: tb/tb_egress_arbiter.sv
// ---------------------------------------------------------------------------
// tb_egress_arbiter
// Bench for egress_arbiter. The bench plays the four class FIFOs; each pop
// is judged against round-robin rules and queues the expected push, which a
// separate monitor compares against push/data_out.
// ---------------------------------------------------------------------------
module tb_egress_arbiter;
    import egress_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic        empty_0, empty_1, empty_2, empty_3;
    logic [11:0] data_in_0, data_in_1, data_in_2, data_in_3;
    logic        pop_0, pop_1, pop_2, pop_3;
    logic        almost_full_out;
    logic        push;
    logic [11:0] data_out;
    logic        idle;
    logic [7:0]  word_cnt_0, word_cnt_1, word_cnt_2, word_cnt_3;

`ifdef ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [11:0] data;
        int          ch;
        int          cyc;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          pop_count = 0;

    logic [11:0] fmem [4][1024];
    int          fhead [4];
    int          ftail [4];
    logic [11:0] din [4];
    exp_t        sb [$];
    logic [11:0] got_data [$];
    int          got_cyc [$];
    int          mcnt [4];

    int          model_last = 3;
    bit          prev_pop   = 1'b0;
    bit          prev_allow = 1'b0;
    logic [3:0]  prev_ne    = 4'b0;

    assign empty_0   = (fhead[0] == ftail[0]);
    assign empty_1   = (fhead[1] == ftail[1]);
    assign empty_2   = (fhead[2] == ftail[2]);
    assign empty_3   = (fhead[3] == ftail[3]);
    assign data_in_0 = din[0];
    assign data_in_1 = din[1];
    assign data_in_2 = din[2];
    assign data_in_3 = din[3];

    egress_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .state           (state),
        .empty_0         (empty_0),
        .empty_1         (empty_1),
        .empty_2         (empty_2),
        .empty_3         (empty_3),
        .data_in_0       (data_in_0),
        .data_in_1       (data_in_1),
        .data_in_2       (data_in_2),
        .data_in_3       (data_in_3),
        .pop_0           (pop_0),
        .pop_1           (pop_1),
        .pop_2           (pop_2),
        .pop_3           (pop_3),
        .almost_full_out (almost_full_out),
        .push            (push),
        .data_out        (data_out),
        .idle            (idle),
        .word_cnt_0      (word_cnt_0),
        .word_cnt_1      (word_cnt_1),
        .word_cnt_2      (word_cnt_2),
        .word_cnt_3      (word_cnt_3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // First non-empty channel after the last grant, wrapping back to it
    function automatic int rr_expect(input int last, input logic [3:0] ne);
        int c;
        for (int off = 1; off <= 4; off++) begin
            c = (last + off) % 4;
            if (ne[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < 4; i++) begin
            if (fhead[i] != ftail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // FIFO model and pop-rule checker. Snapshots of the previous cycle are the
    // inputs the DUT saw at the edge where it made the grant.
    always @(negedge clk) begin : responder
        logic [3:0] pops;
        int         k;
        int         exp_k;
        pops = {pop_3, pop_2, pop_1, pop_0};
        if (reset) begin
            model_last = 3;
            prev_pop   = 1'b0;
            prev_allow = 1'b0;
            prev_ne    = 4'b0;
        end else begin
            if (pops != 4'b0) begin
                pop_count++;
                k = 0;
                for (int i = 3; i >= 0; i--) begin
                    if (pops[i]) k = i;
                end
                exp_k = rr_expect(model_last, prev_ne);
                check("pop_onehot", {31'b0, $onehot(pops)}, 32'd1);
                check("pop_back_to_back", {31'b0, prev_pop}, 32'd0);
                check("pop_grant_allowed", {31'b0, prev_allow}, 32'd1);
                check("pop_rr_channel", k, exp_k);
                check("pop_while_empty", {31'b0, fhead[k] == ftail[k]}, 32'd0);
                if (fhead[k] != ftail[k]) begin
                    din[k] = fmem[k][fhead[k]];
                    fhead[k]++;
                    sb.push_back('{data: din[k], ch: k, cyc: cyc + 2});
                end
                model_last = k;
            end
            prev_pop   = (pops != 4'b0);
            prev_allow = !almost_full_out && fwd_enabled(state);
            prev_ne    = {~empty_3, ~empty_2, ~empty_1, ~empty_0};
            if (state == LINK_RESET) model_last = 3;
        end
    end

    // Output monitor: every push must match the oldest expected word
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            for (int i = 0; i < 4; i++) mcnt[i] = 0;
        end else begin
            if (push) begin
                got_data.push_back(data_out);
                got_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("push_unexpected", {31'b0, push}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("push_data", {20'b0, data_out}, {20'b0, e.data});
                    check("push_latency", cyc, e.cyc);
                    if (mcnt[e.ch] < 255) mcnt[e.ch]++;
                end
            end
            if (state == LINK_RESET) begin
                for (int i = 0; i < 4; i++) mcnt[i] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input logic [11:0] w);
        fmem[ch][ftail[ch]] = w;
        ftail[ch]++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset           = 1'b1;
        state           = LINK_INIT;
        almost_full_out = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fhead[i] = 0;
            ftail[i] = 0;
            din[i]   = 12'h000;
        end
        sb.delete();
        got_data.delete();
        got_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_pop(input string nm, input int ch, input int budget);
        int         n;
        logic [3:0] p;
        n = 0;
        p = 4'b0;
        while (!p[ch] && n < budget) begin
            @(negedge clk);
            p = {pop_3, pop_2, pop_1, pop_0};
            n++;
        end
        check({nm, "_pop_seen"}, {31'b0, p[ch]}, 32'd1);
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while (!(all_empty() && sb.size() == 0 && idle === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_drain_in_time"}, {31'b0, n < budget}, 32'd1);
        check({nm, "_idle"}, {31'b0, idle}, 32'd1);
        check({nm, "_sb_left"}, sb.size(), 0);
    endtask

    task automatic check_counts(input string nm);
        check({nm, "_cnt0"}, {24'b0, word_cnt_0}, STATS ? mcnt[0] : 0);
        check({nm, "_cnt1"}, {24'b0, word_cnt_1}, STATS ? mcnt[1] : 0);
        check({nm, "_cnt2"}, {24'b0, word_cnt_2}, STATS ? mcnt[2] : 0);
        check({nm, "_cnt3"}, {24'b0, word_cnt_3}, STATS ? mcnt[3] : 0);
    endtask

    task automatic check_spacing(input string nm);
        for (int i = 1; i < got_cyc.size(); i++) begin
            check({nm, "_push_spacing"}, got_cyc[i] - got_cyc[i-1], 2);
        end
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_pops"}, {28'b0, pop_3, pop_2, pop_1, pop_0}, 32'd0);
        check({nm, "_push"}, {31'b0, push}, 32'd0);
        check({nm, "_data_out"}, {20'b0, data_out}, 32'd0);
        check({nm, "_idle"}, {31'b0, idle}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        reset           = 1'b1;
        state           = LINK_RESET;
        almost_full_out = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fhead[i] = 0;
            ftail[i] = 0;
            din[i]   = 12'h000;
            mcnt[i]  = 0;
        end

        // Reset values
        #1;
        check_quiet("reset");
        check_counts("reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        state = LINK_INIT;
        tick();
        check_quiet("post_reset");

        // Four channels, one word each: strict 0..3 order, push every 2 cycles
        for (int ch = 0; ch < 4; ch++) load(ch, 12'(12'hA00 + ch));
        tick();
        state = LINK_ACTIVE;
        drain("rr4", 100);
        check("rr4_count", got_data.size(), 4);
        for (int i = 0; i < got_data.size(); i++) begin
            check("rr4_order", {20'b0, got_data[i]}, 32'hA00 + i);
        end
        check_spacing("rr4");

        // Single channel with three words
        got_data.delete();
        got_cyc.delete();
        tick();
        load(2, 12'hB00);
        load(2, 12'hB01);
        load(2, 12'hB02);
        drain("ch2", 100);
        check("ch2_count", got_data.size(), 3);
        check_spacing("ch2");

        // almost_full rises during CAPTURE of channel 1's word
        got_data.delete();
        got_cyc.delete();
        tick();
        load(1, 12'hC10);
        load(1, 12'hC11);
        wait_pop("af", 1, 50);
        tick();
        almost_full_out = 1'b1;
        pc = pop_count;
        repeat (10) tick();
        check("af_no_new_pop", pop_count, pc);
        check("af_word_pushed", got_data.size(), 1);
        if (got_data.size() > 0) check("af_word", {20'b0, got_data[0]}, 32'hC10);
        almost_full_out = 1'b0;
        drain("af", 100);
        check("af_total", got_data.size(), 2);

        // Link leaves active mid-word, then link reset clears everything
        got_data.delete();
        got_cyc.delete();
        tick();
        load(3, 12'hD30);
        load(3, 12'hD31);
        wait_pop("lnk", 3, 50);
        tick();
        state = LINK_INIT;
        pc = pop_count;
        repeat (10) tick();
        check("lnk_no_new_pop", pop_count, pc);
        check("lnk_one_push", got_data.size(), 1);
        check("lnk_data_held", {20'b0, data_out}, 32'hD30);
        check_counts("pre_clear");
        state = LINK_RESET;
        tick();
        check_quiet("sync_clear");
        check_counts("sync_clear");
        do_reset();

        // Reset asserted during CAPTURE drops the word
        tick();
        load(0, 12'hE00);
        state = LINK_ACTIVE;
        wait_pop("rst", 0, 50);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_quiet("rst_capture");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) tick();
        check("rst_no_push", got_data.size(), 0);
        check("rst_idle", {31'b0, idle}, 32'd1);

        // Randomised traffic, back-pressure and link-state changes
        do_reset();
        repeat (3000) begin
            tick();
            if ($urandom_range(3) == 0) load($urandom_range(3), 12'($urandom));
            almost_full_out = ($urandom_range(4) == 0);
            if ($urandom_range(15) == 0) begin
                case ($urandom_range(3))
                    0:       state = LINK_INIT;
                    1:       state = LINK_IDLE;
                    default: state = LINK_ACTIVE;
                endcase
            end
        end
        tick();
        state           = LINK_ACTIVE;
        almost_full_out = 1'b0;
        drain("rand", 3000);
        check_counts("rand");

        // 300 words on channel 0: counter saturates, others stay 0
        do_reset();
        for (int i = 0; i < 300; i++) load(0, 12'(i));
        tick();
        state = LINK_ACTIVE;
        drain("sat", 1500);
        check("sat_count", got_data.size(), 300);
        check("sat_cnt0", {24'b0, word_cnt_0}, STATS ? 32'd255 : 32'd0);
        check_counts("sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
